// File: rtl/fsmc_pkg.sv
// Shared definitions for the FSMC bus front-end.
//   DW_DEF / AW_DEF : default data / address widths
//   ERR_MAX         : saturation value of the protocol error counter
//   fsmc_state_t    : front-end FSM state encoding
package fsmc_pkg;

    localparam int         DW_DEF  = 16;
    localparam int         AW_DEF  = 2;
    localparam logic [7:0] ERR_MAX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        WR_Q,
        WR_HOLD,
        RD_Q,
        RD_LAT,
        RD_DRV,
        ERR
    } fsmc_state_t;

endpackage

// File: rtl/fsmc_sync.sv
// Multi-flop synchroniser for one asynchronous, active-low control input.
// All stages reset to 1 so that the synchronised signal reads as inactive.
//   clk   in  system clock
//   reset in  synchronous, active-high reset
//   din   in  asynchronous input
//   dout  out synchronised output (last stage)
module fsmc_sync #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [SYNC-1:0] stages;

    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '1;
        end else begin
            stages <= {stages[SYNC-2:0], din};
        end
    end

    assign dout = stages[SYNC-1];

endmodule

// File: rtl/fsmc_front.sv
// FSMC bus front-end: synchronises nce/noe/nwe, qualifies them against glitches,
// and turns bus cycles into single-cycle write/read strobes. Returns read data
// for the pad-level tristate buffer.
//   clk, reset         clock and synchronous active-high reset
//   nce, noe, nwe      asynchronous FSMC controls (active-low)
//   addr, data_in      FSMC address and incoming bus value
//   data_out, data_oe  read-return value and drive enable for the pad buffer
//   wr_stb/addr/data   one-cycle write pulse with captured address/data
//   rd_stb/addr        one-cycle read request with captured address
//   rd_data            consumer data, valid the cycle after rd_stb
//   err_cnt            saturating count of noe/nwe-both-low protocol errors
module fsmc_front
    import fsmc_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int SYNC    = 2,
    parameter int MIN_LOW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          nce,
    input  logic          noe,
    input  logic          nwe,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          data_oe,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          rd_stb,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [7:0]    err_cnt
);

    localparam int            CW       = $clog2(MIN_LOW + 1);
    localparam logic [CW-1:0] LOW_LAST = CW'(MIN_LOW - 1);

    logic          ce_s, oe_s, we_s;
    fsmc_state_t   state;
    logic [CW-1:0] low_cnt;
    logic          lat_wait;

    fsmc_sync #(.SYNC(SYNC)) u_sync_ce (.clk(clk), .reset(reset), .din(nce), .dout(ce_s));
    fsmc_sync #(.SYNC(SYNC)) u_sync_oe (.clk(clk), .reset(reset), .din(noe), .dout(oe_s));
    fsmc_sync #(.SYNC(SYNC)) u_sync_we (.clk(clk), .reset(reset), .din(nwe), .dout(we_s));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            low_cnt  <= '0;
            lat_wait <= 1'b0;
            wr_stb   <= 1'b0;
            rd_stb   <= 1'b0;
            data_oe  <= 1'b0;
            data_out <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_addr  <= '0;
            err_cnt  <= '0;
        end else begin
            wr_stb <= 1'b0;
            rd_stb <= 1'b0;

            // Protocol error outranks everything, then chip-deselect abort.
            if (!oe_s && !we_s) begin
                data_oe <= 1'b0;
                if (state != ERR && err_cnt != ERR_MAX) begin
                    err_cnt <= err_cnt + 8'd1;
                end
                state <= ERR;
            end else if (ce_s && state != IDLE && state != ERR) begin
                data_oe <= 1'b0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!ce_s && !we_s) begin
                            low_cnt <= '0;
                            state   <= WR_Q;
                        end else if (!ce_s && !oe_s) begin
                            low_cnt <= '0;
                            state   <= RD_Q;
                        end
                    end
                    WR_Q: begin
                        if (we_s) begin
                            state <= IDLE;
                        end else if (low_cnt == LOW_LAST) begin
                            // Capture on qualification too, so a write that ends
                            // right after it still carries this cycle's values.
                            wr_addr <= addr;
                            wr_data <= data_in;
                            state   <= WR_HOLD;
                        end else begin
                            low_cnt <= low_cnt + 1'b1;
                        end
                    end
                    WR_HOLD: begin
                        if (we_s) begin
                            wr_stb <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            wr_addr <= addr;
                            wr_data <= data_in;
                        end
                    end
                    RD_Q: begin
                        if (oe_s) begin
                            state <= IDLE;
                        end else if (low_cnt == LOW_LAST) begin
                            rd_stb   <= 1'b1;
                            rd_addr  <= addr;
                            lat_wait <= 1'b1;
                            state    <= RD_LAT;
                        end else begin
                            low_cnt <= low_cnt + 1'b1;
                        end
                    end
                    RD_LAT: begin
                        // First cycle is the rd_stb cycle; the consumer's data
                        // arrives the cycle after.
                        if (lat_wait) begin
                            lat_wait <= 1'b0;
                        end else begin
                            data_out <= rd_data;
                            data_oe  <= !oe_s;
                            state    <= RD_DRV;
                        end
                    end
                    RD_DRV: begin
                        if (oe_s) begin
                            data_oe <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            data_oe <= 1'b1;
                        end
                    end
                    ERR: begin
                        if (oe_s && we_s) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        data_oe <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fsmc_front.sv
// Directed testbench for fsmc_front with a strobe scoreboard.
module tb_fsmc_front;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        nce = 1'b1, noe = 1'b1, nwe = 1'b1;
    logic [1:0]  addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        data_oe;
    logic        wr_stb;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_stb;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data = '0;
    logic [7:0]  err_cnt;

    fsmc_front #(.DW(16), .AW(2), .SYNC(SYNC), .MIN_LOW(2)) dut (
        .clk(clk), .reset(reset), .nce(nce), .noe(noe), .nwe(nwe),
        .addr(addr), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_stb(rd_stb), .rd_addr(rd_addr), .rd_data(rd_data), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  a;
        logic [15:0] d;
    } wr_exp_t;

    wr_exp_t    wr_q[$];
    logic [1:0] rd_q[$];
    wr_exp_t    wr_tmp;
    logic [1:0] rd_tmp;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_seen = 0;
    int rd_seen = 0;
    int wr_last_cyc = 0;
    int t_rise;
    logic [15:0] rd_value = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer model: data valid only in the cycle after rd_stb.
    always @(posedge clk) rd_data <= (rd_stb === 1'b1) ? rd_value : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_stb === 1'b1 || rd_stb === 1'b1)
                check("stb_exclusive", {31'd0, wr_stb & rd_stb}, 32'd0);
            if (data_oe === 1'b1)
                check("oe_while_nwe_low", {31'd0, nwe}, 32'd1);
            if (wr_stb === 1'b1) begin
                wr_seen++;
                wr_last_cyc = cyc;
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    wr_tmp = wr_q.pop_front();
                    check("wr_addr", {30'd0, wr_addr}, {30'd0, wr_tmp.a});
                    check("wr_data", {16'd0, wr_data}, {16'd0, wr_tmp.d});
                end
            end
            if (rd_stb === 1'b1) begin
                rd_seen++;
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    rd_tmp = rd_q.pop_front();
                    check("rd_addr", {30'd0, rd_addr}, {30'd0, rd_tmp});
                end
            end
        end
    end

    initial begin
        // Reset state
        tick(3);
        check("rst_wr_stb",  {31'd0, wr_stb},   32'd0);
        check("rst_rd_stb",  {31'd0, rd_stb},   32'd0);
        check("rst_data_oe", {31'd0, data_oe},  32'd0);
        check("rst_data_out", {16'd0, data_out}, 32'd0);
        check("rst_wr_addr", {30'd0, wr_addr},  32'd0);
        check("rst_wr_data", {16'd0, wr_data},  32'd0);
        check("rst_rd_addr", {30'd0, rd_addr},  32'd0);
        check("rst_err_cnt", {24'd0, err_cnt},  32'd0);
        reset = 1'b0;
        tick(2);

        // 1: write BEEF to address 0, nwe low 6 clocks
        nce = 1'b0; addr = 2'b00; data_in = 16'hBEEF; nwe = 1'b0;
        wr_q.push_back('{a: 2'b00, d: 16'hBEEF});
        tick(6);
        nwe = 1'b1;
        t_rise = cyc;
        tick(8);
        check("w1_count", wr_seen, 1);
        check("w1_latency", wr_last_cyc - t_rise, SYNC + 1);
        data_in = 16'h0BAD; nce = 1'b1;
        tick(4);

        // 2: read address 1, consumer returns 1234
        rd_value = 16'h1234;
        nce = 1'b0; addr = 2'b01; noe = 1'b0;
        rd_q.push_back(2'b01);
        tick(8);
        check("r2_count", rd_seen, 1);
        check("r2_oe_on", {31'd0, data_oe}, 32'd1);
        check("r2_data_out", {16'd0, data_out}, 32'h1234);
        noe = 1'b1;
        tick(2);
        check("r2_oe_until_sync", {31'd0, data_oe}, 32'd1);
        tick(1);
        check("r2_oe_off", {31'd0, data_oe}, 32'd0);
        check("r2_data_hold", {16'd0, data_out}, 32'h1234);
        nce = 1'b1;
        tick(4);

        // 3: nwe glitch of one clock, then a normal write to show IDLE recovery
        nce = 1'b0; addr = 2'b10; data_in = 16'h1111;
        tick(4);
        nwe = 1'b0;
        tick(1);
        nwe = 1'b1;
        tick(8);
        check("g3_no_wr", wr_seen, 1);
        check("g3_err_cnt", {24'd0, err_cnt}, 32'd0);
        addr = 2'b11; data_in = 16'h55AA; nwe = 1'b0;
        wr_q.push_back('{a: 2'b11, d: 16'h55AA});
        tick(5);
        nwe = 1'b1;
        tick(8);
        check("g3_write_after", wr_seen, 2);
        data_in = 16'h0BAD; nce = 1'b1;
        tick(4);

        // 4: noe low one clock, then deselect
        nce = 1'b0; addr = 2'b01;
        tick(4);
        noe = 1'b0;
        tick(1);
        noe = 1'b1; nce = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("a4_oe_low", {31'd0, data_oe}, 32'd0);
        end
        check("a4_no_rd", rd_seen, 1);

        // 5: noe and nwe low together, repeated 300 times
        nce = 1'b0;
        tick(4);
        for (int n = 1; n <= 300; n++) begin
            noe = 1'b0; nwe = 1'b0;
            tick(4);
            noe = 1'b1; nwe = 1'b1;
            tick(4);
            if (n == 1)   check("e5_first",   {24'd0, err_cnt}, 32'd1);
            if (n == 255) check("e5_reach",   {24'd0, err_cnt}, 32'd255);
        end
        check("e5_saturate", {24'd0, err_cnt}, 32'd255);
        check("e5_no_wr", wr_seen, 2);
        check("e5_no_rd", rd_seen, 1);
        nce = 1'b1;
        tick(4);

        // 6: reset while driving read data, then a fresh read
        rd_value = 16'hC3C3;
        nce = 1'b0; addr = 2'b11; noe = 1'b0;
        rd_q.push_back(2'b11);
        tick(8);
        check("r6_oe_before", {31'd0, data_oe}, 32'd1);
        reset = 1'b1; noe = 1'b1; nce = 1'b1;
        tick(1);
        check("r6_oe_reset",   {31'd0, data_oe},  32'd0);
        check("r6_err_reset",  {24'd0, err_cnt},  32'd0);
        check("r6_dout_reset", {16'd0, data_out}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(3);
        rd_value = 16'h5A5A;
        nce = 1'b0; addr = 2'b10; noe = 1'b0;
        rd_q.push_back(2'b10);
        tick(8);
        check("r6_oe_again",   {31'd0, data_oe},  32'd1);
        check("r6_dout_again", {16'd0, data_out}, 32'h5A5A);
        noe = 1'b1; nce = 1'b1;
        tick(6);
        check("r6_oe_end", {31'd0, data_oe}, 32'd0);

        check("end_wr_total", wr_seen, 2);
        check("end_rd_total", rd_seen, 3);
        check("end_wr_q_empty", wr_q.size(), 0);
        check("end_rd_q_empty", rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
